// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the I/D cache to physical memory arbiter
package lc3b_types;

    // One full cache line as carried on the physical memory bus.
    typedef logic [127:0] lc3b_line;

    // Arbiter FSM: idle, or owned by the I-cache or the D-cache.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    // Round-robin pointer encoding: 1 means D wins the next tie.
    localparam logic PTR_FAVOUR_D = 1'b1;
    localparam logic PTR_FAVOUR_I = 1'b0;

    // Result of grant selection for one IDLE cycle.
    typedef struct packed {
        logic valid;
        logic to_d;
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_grant_sel.sv
// rtl/cache_arbiter_grant_sel.sv - combinational grant selection between I and D requesters
module arb_grant_sel
    import lc3b_types::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_favour_d,
    output arb_grant_t o_grant
);

    // A tie goes to whichever side the pointer favours; a lone request always wins.
    always_comb begin
        o_grant       = '0;
        o_grant.valid = i_req_i | i_req_d;
        o_grant.to_d  = i_req_d & (~i_req_i | i_favour_d);
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates I/D cache line traffic onto one physical memory port (option: ARB_ROUND_ROBIN_EN)
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              I_pmem_read,
    input  logic [ADDR_W-1:0] I_pmem_address,
    output logic              I_pmem_resp,
    output logic [LINE_W-1:0] I_pmem_rdata,

    input  logic              D_pmem_read,
    input  logic              D_pmem_write,
    input  logic [ADDR_W-1:0] D_pmem_address,
    input  logic [LINE_W-1:0] D_pmem_wdata,
    output logic              D_pmem_resp,
    output logic [LINE_W-1:0] D_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic              w_pmem_read_next;
    logic              w_pmem_write_next;
    logic [ADDR_W-1:0] w_pmem_address_next;
    logic [LINE_W-1:0] w_pmem_wdata_next;

    logic              w_d_req;
    logic              w_favour_d;
    arb_grant_t        w_grant;

    assign w_d_req = D_pmem_read | D_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_favour_d;
    logic w_favour_d_next;

    assign w_favour_d = r_favour_d;

    // Only a contested grant moves the pointer, so a lone request never steals the next tie.
    always_comb begin
        w_favour_d_next = r_favour_d;
        if (r_state == IDLE && I_pmem_read && w_d_req) begin
            w_favour_d_next = ~w_grant.to_d;
        end
    end

    // Tie-break pointer; reset leaves D favoured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_favour_d <= PTR_FAVOUR_D;
        end else begin
            r_favour_d <= w_favour_d_next;
        end
    end
`else
    assign w_favour_d = PTR_FAVOUR_D;
`endif

    arb_grant_sel u_grant_sel (
        .i_req_i    (I_pmem_read),
        .i_req_d    (w_d_req),
        .i_favour_d (w_favour_d),
        .o_grant    (w_grant)
    );

    // Next state and next memory command; the command is frozen for the whole BUSY phase.
    always_comb begin
        w_state_next        = r_state;
        w_pmem_read_next    = r_pmem_read;
        w_pmem_write_next   = r_pmem_write;
        w_pmem_address_next = r_pmem_address;
        w_pmem_wdata_next   = r_pmem_wdata;
        case (r_state)
            IDLE: begin
                if (w_grant.valid) begin
                    if (w_grant.to_d) begin
                        w_state_next        = D_BUSY;
                        w_pmem_address_next = D_pmem_address;
                        w_pmem_wdata_next   = D_pmem_wdata;
                        // A simultaneous read and write from D is treated as the writeback.
                        w_pmem_write_next   = D_pmem_write;
                        w_pmem_read_next    = ~D_pmem_write;
                    end else begin
                        w_state_next        = I_BUSY;
                        w_pmem_address_next = I_pmem_address;
                        w_pmem_read_next    = 1'b1;
                        w_pmem_write_next   = 1'b0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    w_state_next      = IDLE;
                    w_pmem_read_next  = 1'b0;
                    w_pmem_write_next = 1'b0;
                end
            end
            default: begin
                w_state_next      = IDLE;
                w_pmem_read_next  = 1'b0;
                w_pmem_write_next = 1'b0;
            end
        endcase
    end

    // State and registered memory command; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pmem_read    <= w_pmem_read_next;
            r_pmem_write   <= w_pmem_write_next;
            r_pmem_address <= w_pmem_address_next;
            r_pmem_wdata   <= w_pmem_wdata_next;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Read data fans out unconditionally; the owner's resp is the only qualifier.
    assign I_pmem_rdata = pmem_rdata;
    assign D_pmem_rdata = pmem_rdata;
    assign I_pmem_resp  = (r_state == I_BUSY) & pmem_resp;
    assign D_pmem_resp  = (r_state == D_BUSY) & pmem_resp;

endmodule
